// File: rtl/dm_arb_pkg.sv
// -----------------------------------------------------------------------------
// dm_arb_pkg
// Shared definitions for the RAM_B two-port arbiter:
//   - arb_state_e : sequencer states (IDLE, ACCESS, RDWAIT)
//   - PORT0/PORT1 : port-index constants used by the picker and the arbiter
//   - AW_DEFAULT / DW_DEFAULT : default word-address and data widths
//   - port_onehot : turns a port index into a {port1, port0} one-hot pulse
// -----------------------------------------------------------------------------
package dm_arb_pkg;

  localparam int AW_DEFAULT = 6;
  localparam int DW_DEFAULT = 32;

  localparam logic PORT0 = 1'b0;
  localparam logic PORT1 = 1'b1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RDWAIT = 2'd2
  } arb_state_e;

  function automatic logic [1:0] port_onehot(input logic idx);
    return (idx == PORT1) ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/dm_arbiter_if.sv
// -----------------------------------------------------------------------------
// dm_arbiter_if
// Bundles the two requester ports and the RAM_B memory port of dm_arbiter.
//   Requester side : req0/1, we0/1, addr0/1, wdata0/1 (to arbiter)
//                    gnt0/1, rvalid0/1, rdata          (from arbiter)
//   Memory side    : Mem_Write, DM_Addr, M_W_Data      (from arbiter)
//                    M_R_Data                          (to arbiter)
// Modports:
//   slave  : the arbiter's view
//   master : the environment's view (requesters plus RAM_B)
// -----------------------------------------------------------------------------
interface dm_arbiter_if
  import dm_arb_pkg::*;
#(
  parameter int AW = AW_DEFAULT,
  parameter int DW = DW_DEFAULT
) ();

  logic          req0,   req1;
  logic          we0,    we1;
  logic [AW-1:0] addr0,  addr1;
  logic [DW-1:0] wdata0, wdata1;
  logic          gnt0,   gnt1;
  logic          rvalid0, rvalid1;
  logic [DW-1:0] rdata;

  logic          Mem_Write;
  logic [AW-1:0] DM_Addr;
  logic [DW-1:0] M_W_Data;
  logic [DW-1:0] M_R_Data;

  modport slave (
    input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, M_R_Data,
    output gnt0, gnt1, rvalid0, rvalid1, rdata, Mem_Write, DM_Addr, M_W_Data
  );

  modport master (
    output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, M_R_Data,
    input  gnt0, gnt1, rvalid0, rvalid1, rdata, Mem_Write, DM_Addr, M_W_Data
  );

endinterface

// File: rtl/rr_pick2.sv
// -----------------------------------------------------------------------------
// rr_pick2
// Combinational two-way round-robin picker.
//   req[1:0] : request lines, bit i = port i
//   ptr      : port that holds priority when both request
//   valid    : at least one request is present
//   idx      : winning port (meaningful only when valid)
// -----------------------------------------------------------------------------
module rr_pick2
  import dm_arb_pkg::*;
(
  input  logic [1:0] req,
  input  logic       ptr,
  output logic       valid,
  output logic       idx
);

  always_comb begin
    valid = |req;
    if (req[0] && req[1]) begin
      idx = ptr;
    end else if (req[1]) begin
      idx = PORT1;
    end else begin
      idx = PORT0;
    end
  end

endmodule

// File: rtl/dm_arbiter.sv
// -----------------------------------------------------------------------------
// dm_arbiter
// Two-port round-robin arbiter and access sequencer for RAM_B (64 x 32).
// One access at a time: a grant drives RAM_B for one cycle; writes finish
// there, reads wait one more cycle for the synchronous RAM output and return
// it on the shared rdata bus with a one-cycle rvalid pulse to the winner.
// Ports:
//   clk   : single clock (also clocks RAM_B)
//   rst_n : asynchronous active-low reset
//   bus   : dm_arbiter_if.slave (requester handshakes and RAM_B port)
// -----------------------------------------------------------------------------
module dm_arbiter
  import dm_arb_pkg::*;
#(
  parameter int AW = AW_DEFAULT,
  parameter int DW = DW_DEFAULT
) (
  input  logic         clk,
  input  logic         rst_n,
  dm_arbiter_if.slave  bus
);

  arb_state_e    state_reg, state_next;
  logic          ptr_reg, ptr_next;
  logic          win_reg, win_next;
  logic          we_reg, we_next;
  logic [AW-1:0] addr_reg, addr_next;
  logic [DW-1:0] wdata_reg, wdata_next;
  logic [1:0]    gnt_reg, gnt_next;
  logic [1:0]    rvalid_reg, rvalid_next;
  logic [DW-1:0] rdata_reg, rdata_next;
  logic          mem_write_reg, mem_write_next;

  logic          pick_valid;
  logic          pick_idx;
  logic          sel_we;
  logic [AW-1:0] sel_addr;
  logic [DW-1:0] sel_wdata;

  rr_pick2 u_pick (
    .req   ({bus.req1, bus.req0}),
    .ptr   (ptr_reg),
    .valid (pick_valid),
    .idx   (pick_idx)
  );

  // Fields of whichever port the picker currently favours.
  assign sel_we    = (pick_idx == PORT1) ? bus.we1    : bus.we0;
  assign sel_addr  = (pick_idx == PORT1) ? bus.addr1  : bus.addr0;
  assign sel_wdata = (pick_idx == PORT1) ? bus.wdata1 : bus.wdata0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      ptr_reg       <= PORT0;
      win_reg       <= PORT0;
      we_reg        <= 1'b0;
      addr_reg      <= '0;
      wdata_reg     <= '0;
      gnt_reg       <= '0;
      rvalid_reg    <= '0;
      rdata_reg     <= '0;
      mem_write_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      ptr_reg       <= ptr_next;
      win_reg       <= win_next;
      we_reg        <= we_next;
      addr_reg      <= addr_next;
      wdata_reg     <= wdata_next;
      gnt_reg       <= gnt_next;
      rvalid_reg    <= rvalid_next;
      rdata_reg     <= rdata_next;
      mem_write_reg <= mem_write_next;
    end
  end

  // Outputs are all registered: every *_next value computed here becomes
  // visible in the cycle after the state that produced it.
  always_comb begin
    state_next     = state_reg;
    ptr_next       = ptr_reg;
    win_next       = win_reg;
    we_next        = we_reg;
    addr_next      = addr_reg;
    wdata_next     = wdata_reg;
    gnt_next       = '0;
    rvalid_next    = '0;
    rdata_next     = rdata_reg;
    mem_write_next = 1'b0;

    unique case (state_reg)
      IDLE: begin
        if (pick_valid) begin
          win_next       = pick_idx;
          we_next        = sel_we;
          addr_next      = sel_addr;
          wdata_next     = sel_wdata;
          gnt_next       = port_onehot(pick_idx);
          // Write enable is set only for the ACCESS cycle that follows.
          mem_write_next = sel_we;
          // Priority passes to the port that did not win.
          ptr_next       = ~pick_idx;
          state_next     = ACCESS;
        end
      end
      ACCESS: begin
        state_next = we_reg ? IDLE : RDWAIT;
      end
      RDWAIT: begin
        // RAM_B output now reflects the address presented during ACCESS.
        rdata_next  = bus.M_R_Data;
        rvalid_next = port_onehot(win_reg);
        state_next  = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign bus.gnt0      = gnt_reg[0];
  assign bus.gnt1      = gnt_reg[1];
  assign bus.rvalid0   = rvalid_reg[0];
  assign bus.rvalid1   = rvalid_reg[1];
  assign bus.rdata     = rdata_reg;
  assign bus.Mem_Write = mem_write_reg;
  assign bus.DM_Addr   = addr_reg;
  assign bus.M_W_Data  = wdata_reg;

endmodule

// File: tb/tb_dm_arbiter.sv
// -----------------------------------------------------------------------------
// tb_dm_arbiter
// Self-checking bench for dm_arbiter with a behavioural RAM_B behind it.
// The reference model keeps the priority port, the expected memory image and
// the last returned read word, and derives the expected cycle of every grant
// and read return from the access rules (write: 2 cycles, read: 3 cycles).
// -----------------------------------------------------------------------------
module tb_dm_arbiter;

  logic clk;
  logic rst_n;

  dm_arbiter_if #(.AW(6), .DW(32)) bus ();

  dm_arbiter #(.AW(6), .DW(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // RAM_B: synchronous write, synchronous read.
  logic [31:0] ram [64];
  always @(posedge clk) begin
    if (bus.Mem_Write) ram[bus.DM_Addr] <= bus.M_W_Data;
    bus.M_R_Data <= ram[bus.DM_Addr];
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned checks = 0;
  int unsigned errors = 0;

  // Reference model state.
  bit          exp_ptr = 1'b0;
  logic [31:0] exp_mem [64];
  logic [31:0] exp_rdata = '0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.req0 = 1'b0; bus.we0 = 1'b0; bus.addr0 = '0; bus.wdata0 = '0;
    bus.req1 = 1'b0; bus.we1 = 1'b0; bus.addr1 = '0; bus.wdata1 = '0;
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    tick();
    tick();
    checks++; if ({bus.gnt1, bus.gnt0, bus.rvalid1, bus.rvalid0} !== 4'b0000) begin errors++; $display("FAIL reset_pulses: got %b want 0000", {bus.gnt1, bus.gnt0, bus.rvalid1, bus.rvalid0}); end
    checks++; if (bus.Mem_Write !== 1'b0) begin errors++; $display("FAIL reset_mem_write: got %b want 0", bus.Mem_Write); end
    checks++; if (bus.DM_Addr !== 6'd0) begin errors++; $display("FAIL reset_dm_addr: got %h want 00", bus.DM_Addr); end
    checks++; if (bus.M_W_Data !== 32'd0) begin errors++; $display("FAIL reset_m_w_data: got %h want 0", bus.M_W_Data); end
    checks++; if (bus.rdata !== 32'd0) begin errors++; $display("FAIL reset_rdata: got %h want 0", bus.rdata); end
    rst_n = 1'b1;
    exp_ptr = 1'b0;
    exp_rdata = '0;
    $display("reset: released after 2 cycles");
  endtask

  // Fresh reset, then both ports request together: port 0 must win first,
  // port 1 (still waiting) second.
  task automatic test_pointer_after_reset();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    exp_ptr = 1'b0;
    exp_rdata = '0;
    bus.req0 = 1'b1; bus.we0 = 1'b1; bus.addr0 = 6'h20; bus.wdata0 = 32'hA0A0_0020;
    bus.req1 = 1'b1; bus.we1 = 1'b1; bus.addr1 = 6'h21; bus.wdata1 = 32'hB1B1_0021;
    tick();
    checks++; if ({bus.gnt1, bus.gnt0} !== 2'b01) begin errors++; $display("FAIL ptr_first_gnt: got %b want 01", {bus.gnt1, bus.gnt0}); end
    bus.req0 = 1'b0;
    exp_mem[6'h20] = 32'hA0A0_0020;
    tick();
    checks++; if ({bus.gnt1, bus.gnt0} !== 2'b00) begin errors++; $display("FAIL ptr_gap: got %b want 00", {bus.gnt1, bus.gnt0}); end
    tick();
    checks++; if ({bus.gnt1, bus.gnt0} !== 2'b10) begin errors++; $display("FAIL ptr_second_gnt: got %b want 10", {bus.gnt1, bus.gnt0}); end
    checks++; if (bus.DM_Addr !== 6'h21) begin errors++; $display("FAIL ptr_second_addr: got %h want 21", bus.DM_Addr); end
    bus.req1 = 1'b0;
    exp_mem[6'h21] = 32'hB1B1_0021;
    exp_ptr = 1'b0;
    tick();
    $display("pointer_after_reset: grants 0 then 1");
  endtask

  task automatic test_single_write();
    bus.req0 = 1'b1; bus.we0 = 1'b1; bus.addr0 = 6'h05; bus.wdata0 = 32'h1234_5678;
    tick();
    checks++; if ({bus.gnt1, bus.gnt0} !== 2'b01) begin errors++; $display("FAIL wr_gnt: got %b want 01", {bus.gnt1, bus.gnt0}); end
    checks++; if (bus.Mem_Write !== 1'b1) begin errors++; $display("FAIL wr_mem_write: got %b want 1", bus.Mem_Write); end
    checks++; if (bus.DM_Addr !== 6'h05) begin errors++; $display("FAIL wr_addr: got %h want 05", bus.DM_Addr); end
    checks++; if (bus.M_W_Data !== 32'h1234_5678) begin errors++; $display("FAIL wr_data: got %h want 12345678", bus.M_W_Data); end
    bus.req0 = 1'b0;
    exp_mem[6'h05] = 32'h1234_5678;
    exp_ptr = 1'b1;
    tick();
    checks++; if ({bus.gnt1, bus.gnt0, bus.Mem_Write} !== 3'b000) begin errors++; $display("FAIL wr_after: got gnt/we %b want 000", {bus.gnt1, bus.gnt0, bus.Mem_Write}); end
    $display("single_write: addr 05 data 12345678");
  endtask

  task automatic test_single_read();
    bus.req1 = 1'b1; bus.we1 = 1'b0; bus.addr1 = 6'h05;
    tick();
    checks++; if ({bus.gnt1, bus.gnt0} !== 2'b10) begin errors++; $display("FAIL rd_gnt: got %b want 10", {bus.gnt1, bus.gnt0}); end
    checks++; if (bus.Mem_Write !== 1'b0) begin errors++; $display("FAIL rd_mem_write: got %b want 0", bus.Mem_Write); end
    bus.req1 = 1'b0;
    exp_ptr = 1'b0;
    tick();
    checks++; if ({bus.rvalid1, bus.rvalid0} !== 2'b00) begin errors++; $display("FAIL rd_early_rvalid: got %b want 00", {bus.rvalid1, bus.rvalid0}); end
    tick();
    checks++; if ({bus.rvalid1, bus.rvalid0} !== 2'b10) begin errors++; $display("FAIL rd_rvalid: got %b want 10", {bus.rvalid1, bus.rvalid0}); end
    checks++; if (bus.rdata !== exp_mem[6'h05]) begin errors++; $display("FAIL rd_data: got %h want %h", bus.rdata, exp_mem[6'h05]); end
    exp_rdata = exp_mem[6'h05];
    tick();
    checks++; if (bus.rdata !== exp_rdata || {bus.rvalid1, bus.rvalid0} !== 2'b00) begin errors++; $display("FAIL rd_hold: got %h/%b want %h/00", bus.rdata, {bus.rvalid1, bus.rvalid0}, exp_rdata); end
    $display("single_read: addr 05 returned %h", bus.rdata);
  endtask

  // Both ports held high continuously: grants must alternate.
  task automatic test_collision();
    bit w;
    bus.req0 = 1'b1; bus.we0 = 1'b1; bus.addr0 = 6'h10; bus.wdata0 = 32'h8765_4321;
    bus.req1 = 1'b1; bus.we1 = 1'b1; bus.addr1 = 6'h11; bus.wdata1 = 32'h0000_1111;
    for (int i = 0; i < 4; i++) begin
      w = exp_ptr;
      tick();
      checks++; if ({bus.gnt1, bus.gnt0} !== (w ? 2'b10 : 2'b01)) begin errors++; $display("FAIL coll_gnt%0d: got %b want %b", i, {bus.gnt1, bus.gnt0}, (w ? 2'b10 : 2'b01)); end
      checks++; if (bus.DM_Addr !== (w ? 6'h11 : 6'h10)) begin errors++; $display("FAIL coll_addr%0d: got %h want %h", i, bus.DM_Addr, (w ? 6'h11 : 6'h10)); end
      exp_mem[w ? 6'h11 : 6'h10] = w ? 32'h0000_1111 : 32'h8765_4321;
      exp_ptr = ~w;
      if (i == 3) begin bus.req0 = 1'b0; bus.req1 = 1'b0; end
      tick();
      checks++; if ({bus.gnt1, bus.gnt0} !== 2'b00) begin errors++; $display("FAIL coll_gap%0d: got %b want 00", i, {bus.gnt1, bus.gnt0}); end
      $display("collision: grant %0d to port %0d", i, w);
    end
  endtask

  task automatic test_back_to_back();
    bus.req0 = 1'b1; bus.we0 = 1'b1; bus.addr0 = 6'h3F; bus.wdata0 = 32'hFFFF_1111;
    tick();
    checks++; if ({bus.gnt1, bus.gnt0} !== 2'b01) begin errors++; $display("FAIL b2b_wr_gnt: got %b want 01", {bus.gnt1, bus.gnt0}); end
    bus.req0 = 1'b0;
    bus.req1 = 1'b1; bus.we1 = 1'b0; bus.addr1 = 6'h3F;
    exp_mem[6'h3F] = 32'hFFFF_1111;
    exp_ptr = 1'b1;
    tick();
    tick();
    checks++; if ({bus.gnt1, bus.gnt0} !== 2'b10) begin errors++; $display("FAIL b2b_rd_gnt: got %b want 10", {bus.gnt1, bus.gnt0}); end
    bus.req1 = 1'b0;
    exp_ptr = 1'b0;
    tick();
    tick();
    checks++; if ({bus.rvalid1, bus.rvalid0} !== 2'b10) begin errors++; $display("FAIL b2b_rvalid: got %b want 10", {bus.rvalid1, bus.rvalid0}); end
    checks++; if (bus.rdata !== 32'hFFFF_1111) begin errors++; $display("FAIL b2b_rdata: got %h want ffff1111", bus.rdata); end
    exp_rdata = 32'hFFFF_1111;
    $display("back_to_back: write then read of 3f returned %h", bus.rdata);
  endtask

  // Random sessions: each port gets 0..3 queued accesses, holding req high
  // until its last one is granted.
  task automatic test_random();
    int          n [2];
    int          k [2];
    logic        cw [2];
    logic [5:0]  ca [2];
    logic [31:0] cd [2];
    bit          r0, r1, w, wr;
    logic [5:0]  wa;
    for (int s = 0; s < 40; s++) begin
      n[0] = $urandom_range(0, 3);
      n[1] = $urandom_range(0, 3);
      if (n[0] + n[1] == 0) n[0] = 1;
      k[0] = 0; k[1] = 0;
      for (int p = 0; p < 2; p++) begin
        cw[p] = 1'($urandom_range(0, 1)); ca[p] = 6'($urandom_range(0, 63)); cd[p] = $urandom;
      end
      bus.req0 = (n[0] > 0); bus.we0 = cw[0]; bus.addr0 = ca[0]; bus.wdata0 = cd[0];
      bus.req1 = (n[1] > 0); bus.we1 = cw[1]; bus.addr1 = ca[1]; bus.wdata1 = cd[1];
      while (k[0] < n[0] || k[1] < n[1]) begin
        r0 = (k[0] < n[0]);
        r1 = (k[1] < n[1]);
        w  = (r0 && r1) ? exp_ptr : r1;
        wr = cw[w];
        wa = ca[w];
        tick();
        checks++; if ({bus.gnt1, bus.gnt0, bus.Mem_Write, bus.DM_Addr} !== {(w ? 2'b10 : 2'b01), wr, wa}) begin errors++; $display("FAIL rnd_grant s%0d: got gnt=%b we=%b addr=%h want gnt=%b we=%b addr=%h", s, {bus.gnt1, bus.gnt0}, bus.Mem_Write, bus.DM_Addr, (w ? 2'b10 : 2'b01), wr, wa); end
        if (wr) begin
          checks++; if (bus.M_W_Data !== cd[w]) begin errors++; $display("FAIL rnd_wdata s%0d: got %h want %h", s, bus.M_W_Data, cd[w]); end
          exp_mem[wa] = cd[w];
        end
        exp_ptr = ~w;
        k[w]++;
        cw[w] = 1'($urandom_range(0, 1)); ca[w] = 6'($urandom_range(0, 63)); cd[w] = $urandom;
        bus.req0 = (k[0] < n[0]); bus.we0 = cw[0]; bus.addr0 = ca[0]; bus.wdata0 = cd[0];
        bus.req1 = (k[1] < n[1]); bus.we1 = cw[1]; bus.addr1 = ca[1]; bus.wdata1 = cd[1];
        tick();
        checks++; if ({bus.gnt1, bus.gnt0, bus.rvalid1, bus.rvalid0, bus.Mem_Write} !== 5'b00000 || bus.rdata !== exp_rdata) begin errors++; $display("FAIL rnd_gap s%0d: got pulses=%b rdata=%h want 00000/%h", s, {bus.gnt1, bus.gnt0, bus.rvalid1, bus.rvalid0, bus.Mem_Write}, bus.rdata, exp_rdata); end
        if (!wr) begin
          tick();
          checks++; if ({bus.rvalid1, bus.rvalid0} !== (w ? 2'b10 : 2'b01) || bus.rdata !== exp_mem[wa]) begin errors++; $display("FAIL rnd_read s%0d: got rvalid=%b rdata=%h want %b/%h", s, {bus.rvalid1, bus.rvalid0}, bus.rdata, (w ? 2'b10 : 2'b01), exp_mem[wa]); end
          exp_rdata = exp_mem[wa];
        end
        $display("random s%0d: port %0d %s addr %h", s, w, wr ? "write" : "read", wa);
      end
    end
    idle_inputs();
  endtask

  task automatic test_reset_mid_read();
    bus.req0 = 1'b1; bus.we0 = 1'b0; bus.addr0 = 6'h10;
    tick();
    checks++; if ({bus.gnt1, bus.gnt0} !== 2'b01) begin errors++; $display("FAIL rst_rd_gnt: got %b want 01", {bus.gnt1, bus.gnt0}); end
    bus.req0 = 1'b0;
    tick();
    rst_n = 1'b0;
    #1;
    checks++; if ({bus.gnt1, bus.gnt0, bus.rvalid1, bus.rvalid0, bus.Mem_Write} !== 5'b00000 || bus.DM_Addr !== 6'd0 || bus.M_W_Data !== 32'd0 || bus.rdata !== 32'd0) begin errors++; $display("FAIL rst_async_clear: got pulses=%b addr=%h wd=%h rd=%h want all 0", {bus.gnt1, bus.gnt0, bus.rvalid1, bus.rvalid0, bus.Mem_Write}, bus.DM_Addr, bus.M_W_Data, bus.rdata); end
    tick();
    checks++; if ({bus.rvalid1, bus.rvalid0} !== 2'b00) begin errors++; $display("FAIL rst_no_rvalid: got %b want 00", {bus.rvalid1, bus.rvalid0}); end
    rst_n = 1'b1;
    exp_ptr = 1'b0;
    exp_rdata = '0;
    bus.req1 = 1'b1; bus.we1 = 1'b0; bus.addr1 = 6'h3F;
    tick();
    checks++; if ({bus.gnt1, bus.gnt0} !== 2'b10) begin errors++; $display("FAIL rst_after_gnt: got %b want 10", {bus.gnt1, bus.gnt0}); end
    bus.req1 = 1'b0;
    tick();
    tick();
    checks++; if ({bus.rvalid1, bus.rvalid0} !== 2'b10 || bus.rdata !== exp_mem[6'h3F]) begin errors++; $display("FAIL rst_after_read: got %b/%h want 10/%h", {bus.rvalid1, bus.rvalid0}, bus.rdata, exp_mem[6'h3F]); end
    $display("reset_mid_read: in-flight read dropped, next read returned %h", bus.rdata);
  endtask

  initial begin
    for (int i = 0; i < 64; i++) begin
      ram[i] = '0;
      exp_mem[i] = '0;
    end
    idle_inputs();
    test_reset();
    test_pointer_after_reset();
    test_single_write();
    test_single_read();
    test_collision();
    test_back_to_back();
    test_random();
    test_reset_mid_read();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule

// File: doc/dm_arbiter.md
# dm_arbiter

Two-port round-robin arbiter and access sequencer for the 64-word × 32-bit data memory (RAM_B). It lets two independent requesters, such as a CPU data port and a debug/display scanner, share the single memory port. It serialises their reads and writes, returns read data to the winning port with a fixed latency, and drives RAM_B's write enable, word address and write data. It sits between the requesters and RAM_B, replacing the direct switch wiring used in the lab top level.

## Interface
Parameters:
- AW, 6, word-address width; addresses are byte-address bits [AW+1:2].
- DW, 32, data width.

Ports:
- clk  in  1  single clock; drives the arbiter and RAM_B.
- rst_n  in  1  asynchronous, active-low reset.
- req0 / req1  in  1  access request; held high with fields stable until the matching gnt.
- we0 / we1  in  1  1 = write, 0 = read.
- addr0 / addr1  in  AW (bits [AW+1:2])  word address.
- wdata0 / wdata1  in  DW  write data.
- gnt0 / gnt1  out  1  one-cycle pulse; the request was accepted.
- rvalid0 / rvalid1  out  1  one-cycle pulse; rdata is valid.
- rdata  out  DW  shared read-return bus; qualified by rvalid0/rvalid1.
- Mem_Write  out  1  RAM_B write enable.
- DM_Addr  out  AW (bits [AW+1:2])  RAM_B word address.
- M_W_Data  out  DW  RAM_B write data.
- M_R_Data  in  DW  RAM_B read data; synchronous, valid the cycle after the address is presented.

## Operation
- FSM states: IDLE, ACCESS, RDWAIT.
- IDLE:
  - If any req is high, choose the winner by round-robin.
  - Latch the winner's we, addr and wdata into the memory-side registers.
  - Set the winner's gnt and go to ACCESS.
  - Otherwise stay in IDLE.
- ACCESS:
  - The memory-side registers are presented to RAM_B.
  - Mem_Write = latched we.
  - gnt for the winner is high in this cycle only.
  - Next state: RDWAIT if read, IDLE if write.
- RDWAIT:
  - Capture M_R_Data into rdata.
  - Set rvalid for the winner and go to IDLE.
- Round-robin rules:
  - A 1-bit pointer holds the port with priority.
  - After each grant, the pointer moves to the other port.
  - On simultaneous requests, the pointer port wins.
  - A single requester wins regardless of the pointer.
- A req dropped before its gnt is withdrawn with no side effect. A req still high after gnt is treated as a new request.
- The arbiter does not modify addresses; it has no wrap-around or range checks. Addresses 0–63 map directly to RAM_B.

## Timing
- A request seen in IDLE in cycle N gives gnt and memory drive in cycle N+1.
  - Write: RAM_B is written at the end of N+1. The arbiter is back in IDLE in N+2. The next grant can appear in N+3.
  - Read: rdata/rvalid are registered and visible in N+3. The arbiter is in IDLE in N+3, so a new grant can appear in N+4.
- Throughput: one write per 2 cycles, one read per 3 cycles.
- rdata holds its last value until the next read completes.
- Reset (rst_n low, asynchronous), all registered outputs clear:
  - state = IDLE, pointer = port 0.
  - gnt0/gnt1/rvalid0/rvalid1 = 0.
  - Mem_Write = 0, DM_Addr = 0, M_W_Data = 0, rdata = 0.
- Reset mid-operation:
  - An in-flight read never produces rvalid.
  - A write asserted in ACCESS is cancelled if reset lands before the clock edge.
- Mem_Write is high only in ACCESS for a write; it is never high in IDLE or RDWAIT.

## Structure
- Package dm_arb_pkg:
  - state enum {IDLE, ACCESS, RDWAIT}.
  - port-index constants PORT0 = 0 and PORT1 = 1.
  - Default values for AW and DW.
- Sub-module rr_pick2:
  - Combinational 2-way round-robin picker.
  - Inputs: req[1:0], ptr. Outputs: valid, idx.
- Pointer update, FSM and output registers live in dm_arbiter.
- The bench instantiates RAM_B behind dm_arbiter.

## Test plan
- Single write: req0 with we0=1, addr0=0x05, wdata0=0x12345678 → gnt0 one cycle later; Mem_Write=1 for one cycle with DM_Addr=0x05.
- Single read: req1 read of addr1=0x05 → gnt1, then rvalid1 two cycles after gnt1 with rdata=0x12345678; rvalid0 stays 0.
- Collision fairness: req0 and req1 both held continuously, port 0 writing 0x87654321 to addr 0x10 and port 1 writing 0x00001111 to addr 0x11 → grants alternate 0,1,0,1; neither port gets two grants in a row.
- Pointer after reset: simultaneous first requests → port 0 wins. Next simultaneous pair → port 1 wins.
- Back-to-back: port 0 writes 0xFFFF1111 to addr 0x3F, then port 1 reads addr 0x3F → rdata=0xFFFF1111.
- Reset mid-read: assert rst_n low in RDWAIT → no rvalid; all outputs 0 immediately; the first request after release is granted normally.
